ram_bist_ctrl: RTL
==================

# ram_bist_ctrl

Sequencing controller that sits directly upstream of the 1024 x 8 `ram` block and drives its address, data-in, write and select pins. On a start pulse it fills every location with a deterministic pattern, then reads each location back through the RAM's data-out, compares it against the expected value, and reports pass/fail, an error count and the first failing address. It replaces bench-level fill/readback loops with a synthesizable self-test that can also run in-system after power-up.

## Interface
Parameters:
- `ADDR_W`, 10, RAM address width
- `DATA_W`, 8, RAM data width
- `DEPTH`, 1024, number of locations tested, equal to 2**ADDR_W

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a test; sampled only in IDLE
- `seed`  in  DATA_W  pattern offset; latched when start is accepted
- `busy`  out  1  high from the first WRITE cycle through the last READ_CHK cycle
- `done`  out  1  one-cycle pulse when the test completes
- `pass`  out  1  1 when the last completed test had zero mismatches; held until the next start
- `err_count`  out  ADDR_W+1  number of mismatching locations in the current or last test
- `first_err_addr`  out  ADDR_W  address of the first mismatch; 0 when there is none
- `ram_addr`  out  ADDR_W  drives the RAM address
- `ram_din`  out  DATA_W  drives the RAM data_in
- `ram_dout`  in  DATA_W  RAM data_out
- `ram_we`  out  1  drives the RAM write
- `ram_sel`  out  1  drives the RAM select

## Operation
- States: IDLE, WRITE, READ_ADDR, READ_CHK, DONE.
- Expected pattern: exp(a) = (2*a + seed_q) mod 2**DATA_W. Compute at DATA_W bits; the carry is discarded, so values wrap.
- IDLE: ram_sel=0, ram_we=0, busy=0. When start=1, latch seed, clear err_count and first_err_addr, set the address counter to 0, and go to WRITE.
- WRITE: ram_sel=1, ram_we=1, ram_addr=a, ram_din=exp(a). Spend one cycle per address. After a=DEPTH-1, reset the counter to 0 and go to READ_ADDR.
- READ_ADDR: ram_sel=1, ram_we=0, ram_addr=a. Go to READ_CHK.
- READ_CHK: hold the same ram_addr with ram_sel=1. Sample ram_dout at the end of the cycle and compare it with exp(a).
  - On a mismatch, increment err_count.
  - If this is the first mismatch, capture a into first_err_addr.
  - If a<DEPTH-1, increment a and go to READ_ADDR. Otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0, pass=(err_count==0). Then go to IDLE.
- start is ignored in every state except IDLE. A start held high through DONE starts a new test on the first IDLE cycle.
- err_count cannot overflow: its maximum is DEPTH, and it is ADDR_W+1 bits wide.
- rst in any state forces IDLE and the reset values below. A test interrupted by rst is abandoned and never produces done. RAM contents are undefined afterwards.

## Timing
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_addr=0, ram_addr=0, ram_din=0, ram_we=0, ram_sel=0.
- All outputs are registered. There is no combinational path from start or ram_dout to any output.
- Start sampled at edge E0:
  - the first WRITE cycle follows E0 and busy rises with it;
  - WRITE occupies DEPTH cycles;
  - the read phase occupies 2*DEPTH cycles;
  - done is high in cycle 3*DEPTH+1 after E0, which is 3073 for the defaults.
- Every write holds ram_we=1 with a stable address and data for exactly one full cycle.
- Read data is sampled one full cycle after the address is presented. This supports both asynchronous-read and one-cycle registered-read RAMs.
- pass, err_count and first_err_addr remain valid from the DONE cycle until the next accepted start.

## Test plan
- Reset: assert rst for 3 cycles with start=1 -> all outputs at their reset values, state IDLE, no RAM writes.
- Full pass with a behavioural 1024x8 RAM, seed=0: pulse start -> location 5 holds 10 and location 200 holds 144; done pulses exactly 3073 cycles after the start edge; pass=1, err_count=0, first_err_addr=0.
- Pattern wrap with seed=8'hFF: run a test -> location 128 holds 255 and location 0 holds 255; pass=1.
- Fault injection: force the RAM model to return data with bit 3 inverted at addresses 300 and 700 -> err_count=2, first_err_addr=300, pass=0.
- Start while busy: pulse start at cycle 100 and at cycle 2000 of a running test -> there is no restart, and done still arrives at cycle 3073.
- Reset mid-test: assert rst during WRITE at a=500, then start again -> no done from the first run; the second run completes with pass=1 at its own 3073-cycle mark.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - fill/readback self-test sequencer for a single-port RAM
module ram_bist_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_we,
  output logic              ram_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_ADDR,
    S_READ_CHK,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   seed_q;
  logic [DATA_W-1:0]   seed_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [ADDR_W-1:0]   first_next;
  logic [ADDR_W:0]     err_next;
  logic                pass_next;
  logic                active_next;

  // exp(a) = 2*a + seed, truncated to DATA_W bits so the pattern wraps
  function automatic logic [DATA_W-1:0] pattern_at(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] s);
    logic [ADDR_W+DATA_W:0] twice;
    twice = {{DATA_W{1'b0}}, a, 1'b0};
    return twice[DATA_W-1:0] + s;
  endfunction

  // ram_addr doubles as the address counter; it returns to 0 outside a test
  always_comb begin
    state_next = state;
    seed_next  = seed_q;
    addr_next  = ram_addr;
    err_next   = err_count;
    first_next = first_err_addr;
    pass_next  = pass;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_WRITE;
          seed_next  = seed;
          addr_next  = '0;
          err_next   = '0;
          first_next = '0;
          pass_next  = 1'b0;
        end
      end
      S_WRITE: begin
        if (ram_addr == LAST_ADDR) begin
          state_next = S_READ_ADDR;
          addr_next  = '0;
        end else begin
          addr_next = ram_addr + 1'b1;
        end
      end
      S_READ_ADDR: state_next = S_READ_CHK;
      S_READ_CHK: begin
        if (ram_dout != pattern_at(ram_addr, seed_q)) begin
          err_next = err_count + 1'b1;
          if (err_count == '0) first_next = ram_addr;
        end
        if (ram_addr == LAST_ADDR) begin
          state_next = S_DONE;
          addr_next  = '0;
          pass_next  = (err_next == '0);
        end else begin
          state_next = S_READ_ADDR;
          addr_next  = ram_addr + 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    active_next = (state_next == S_WRITE) || (state_next == S_READ_ADDR) ||
                  (state_next == S_READ_CHK);
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      seed_q         <= '0;
      ram_addr       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ram_sel        <= 1'b0;
      ram_we         <= 1'b0;
      ram_din        <= '0;
    end else begin
      state          <= state_next;
      seed_q         <= seed_next;
      ram_addr       <= addr_next;
      err_count      <= err_next;
      first_err_addr <= first_next;
      pass           <= pass_next;
      busy           <= active_next;
      done           <= (state_next == S_DONE);
      ram_sel        <= active_next;
      ram_we         <= (state_next == S_WRITE);
      ram_din        <= (state_next == S_WRITE) ? pattern_at(addr_next, seed_next) : '0;
    end
  end

endmodule
